// File: rtl/i_serdes_word_aligner_pkg.sv
// -----------------------------------------------------------------------------
// i_serdes_word_aligner_pkg
// Shared definitions for the I_SERDES word aligner (gen3 IO utilities):
//   - state_e     : alignment FSM states
//   - SLIP_CNT_W  : width of the SLIP_COUNT port and of the internal counters
//   - CNT_MAX     : largest value any alignment counter can hold; bounds the
//                   MATCH_COUNT / SLIP_WAIT / MAX_SLIPS parameters
// -----------------------------------------------------------------------------
package i_serdes_word_aligner_pkg;

  localparam int SLIP_CNT_W = 4;
  localparam int CNT_MAX    = 15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SLIP,
    ST_WAIT,
    ST_LOCKED,
    ST_FAIL
  } state_e;

endpackage

// File: rtl/i_serdes_word_aligner.sv
// -----------------------------------------------------------------------------
// i_serdes_word_aligner
// Sits directly after the I_SERDES deserializer. After ALIGN_START it hunts for
// TRAINING_PATTERN, issuing one-cycle BITSLIP_ADJ pulses until MATCH_COUNT
// consecutive valid words match, then holds ALIGNED. If MAX_SLIPS pulses do not
// produce lock it raises ALIGN_ERROR. The word stream is forwarded with one
// register stage regardless of alignment state.
//
// Ports:
//   CLK_IN          in   fabric clock (same clock as I_SERDES CLK_IN)
//   RST             in   synchronous active-high reset
//   ALIGN_START     in   one-cycle pulse, (re)starts alignment from any state
//   Q_IN            in   [WIDTH] parallel word from I_SERDES Q
//   DATA_VALID_IN   in   qualifies Q_IN
//   BITSLIP_ADJ     out  one-cycle pulse to I_SERDES BITSLIP_ADJ
//   ALIGNED         out  high while locked
//   ALIGN_ERROR     out  high after MAX_SLIPS attempts without lock
//   SLIP_COUNT      out  [4] bitslip pulses issued since the last start
//   Q_OUT           out  [WIDTH] registered Q_IN
//   DATA_VALID_OUT  out  registered DATA_VALID_IN
// -----------------------------------------------------------------------------
module i_serdes_word_aligner
  import i_serdes_word_aligner_pkg::*;
#(
  parameter int               WIDTH            = 4,
  parameter logic [WIDTH-1:0] TRAINING_PATTERN = 4'b1100,
  parameter int               MATCH_COUNT      = 4,
  parameter int               SLIP_WAIT        = 4,
  parameter int               MAX_SLIPS        = 4
) (
  input  logic                  CLK_IN,
  input  logic                  RST,
  input  logic                  ALIGN_START,
  input  logic [WIDTH-1:0]      Q_IN,
  input  logic                  DATA_VALID_IN,
  output logic                  BITSLIP_ADJ,
  output logic                  ALIGNED,
  output logic                  ALIGN_ERROR,
  output logic [SLIP_CNT_W-1:0] SLIP_COUNT,
  output logic [WIDTH-1:0]      Q_OUT,
  output logic                  DATA_VALID_OUT
);

  if (WIDTH < 3 || WIDTH > 10 ||
      MATCH_COUNT < 1 || MATCH_COUNT > CNT_MAX ||
      SLIP_WAIT   < 1 || SLIP_WAIT   > CNT_MAX ||
      MAX_SLIPS   < 1 || MAX_SLIPS   > CNT_MAX) begin : g_bad_param
    $error("i_serdes_word_aligner: parameter out of range");
  end

  localparam logic [SLIP_CNT_W-1:0] MATCH_LAST = SLIP_CNT_W'(MATCH_COUNT);
  localparam logic [SLIP_CNT_W-1:0] WAIT_LAST  = SLIP_CNT_W'(SLIP_WAIT - 1);
  localparam logic [SLIP_CNT_W-1:0] SLIP_LIMIT = SLIP_CNT_W'(MAX_SLIPS);
  localparam logic [SLIP_CNT_W-1:0] SLIP_SAT   = SLIP_CNT_W'(CNT_MAX);

  state_e                  state_q, state_d;
  logic [SLIP_CNT_W-1:0]   match_cnt_q, match_cnt_d;
  logic [SLIP_CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [SLIP_CNT_W-1:0]   slip_cnt_q, slip_cnt_d;
  logic                    bitslip_q, bitslip_d;
  logic                    aligned_q, aligned_d;
  logic                    align_error_q, align_error_d;
  logic [WIDTH-1:0]        q_out_q;
  logic                    dv_out_q;
  logic [SLIP_CNT_W-1:0]   match_inc;

  assign match_inc = match_cnt_q + 1'b1;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    match_cnt_d = match_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    slip_cnt_d  = slip_cnt_q;

    if (ALIGN_START) begin
      state_d     = ST_CHECK;
      match_cnt_d = '0;
      wait_cnt_d  = '0;
      slip_cnt_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: ;
        // Invalid cycles leave CHECK and WAIT frozen.
        ST_CHECK: begin
          if (DATA_VALID_IN) begin
            if (Q_IN == TRAINING_PATTERN) begin
              match_cnt_d = match_inc;
              if (match_inc == MATCH_LAST) state_d = ST_LOCKED;
            end else begin
              match_cnt_d = '0;
              state_d     = (slip_cnt_q >= SLIP_LIMIT) ? ST_FAIL : ST_SLIP;
            end
          end
        end
        // SLIP lasts one cycle whatever DATA_VALID_IN does.
        ST_SLIP: begin
          if (slip_cnt_q != SLIP_SAT) slip_cnt_d = slip_cnt_q + 1'b1;
          wait_cnt_d = '0;
          state_d    = ST_WAIT;
        end
        // Words arriving while the deserializer settles are discarded unseen.
        ST_WAIT: begin
          if (DATA_VALID_IN) begin
            if (wait_cnt_q == WAIT_LAST) begin
              wait_cnt_d = '0;
              state_d    = ST_CHECK;
            end else begin
              wait_cnt_d = wait_cnt_q + 1'b1;
            end
          end
        end
        // User data follows training, so a mismatch here must not drop lock.
        ST_LOCKED: ;
        ST_FAIL:   ;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they are registered yet
  // line up exactly with the state they describe.
  always_comb begin
    bitslip_d     = (state_d == ST_SLIP);
    aligned_d     = (state_d == ST_LOCKED);
    align_error_d = (state_d == ST_FAIL);
  end

  // NOTE: reset is synchronous here, so RST only lives inside the clocked branch.
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      match_cnt_q   <= '0;
      wait_cnt_q    <= '0;
      slip_cnt_q    <= '0;
      bitslip_q     <= 1'b0;
      aligned_q     <= 1'b0;
      align_error_q <= 1'b0;
      q_out_q       <= '0;
      dv_out_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q       <= state_d;
      match_cnt_q   <= match_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      slip_cnt_q    <= slip_cnt_d;
      bitslip_q     <= bitslip_d;
      aligned_q     <= aligned_d;
      align_error_q <= align_error_d;
      q_out_q       <= Q_IN;
      dv_out_q      <= DATA_VALID_IN;
    end
  end

  assign BITSLIP_ADJ    = bitslip_q;
  assign ALIGNED        = aligned_q;
  assign ALIGN_ERROR    = align_error_q;
  assign SLIP_COUNT     = slip_cnt_q;
  assign Q_OUT          = q_out_q;
  assign DATA_VALID_OUT = dv_out_q;

endmodule
